// File: rtl/calc_pkg.sv
// calc_pkg: shared op encoding, latency and record types for the calculator
// command issuer and its FIFOs.
package calc_pkg;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
    localparam int CALC_LAT = 2;
    localparam int TAG_W = 4;
    typedef struct packed {
        op_e              op;
        logic [7:0]       a;
        logic [7:0]       b;
        logic [TAG_W-1:0] tag;
    } cmd_t;
    typedef struct packed {
        logic [7:0]       data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;
    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic             err;
    } stg_t;
endpackage

// File: rtl/calc_issue_if.sv
// calc_issue_if: host command/response handshakes plus the calculator operand
// and result lines; master is the host side, slave is the issuer.
interface calc_issue_if #(parameter int TAG_W = calc_pkg::TAG_W);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [1:0]       calc_op;
    logic [7:0]       calc_in1;
    logic [7:0]       calc_in2;
    logic [7:0]       calc_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, calc_out, rsp_ready,
        input  cmd_ready, calc_op, calc_in1, calc_in2, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, calc_out, rsp_ready,
        output cmd_ready, calc_op, calc_in1, calc_in2, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/calc_fifo.sv
// calc_fifo: synchronous show-ahead FIFO; a write into a full FIFO is taken
// only when a read happens on the same edge.
module calc_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          rd_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] cnt_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr, rd;
    assign rd      = rd_i && cnt_q != '0;
    assign wr      = wr_i && (cnt_q != CW'(DEPTH) || rd);
    assign wp_d    = !wr ? wp_q : wp_q == AW'(DEPTH - 1) ? '0 : wp_q + AW'(1);
    assign rp_d    = !rd ? rp_q : rp_q == AW'(DEPTH - 1) ? '0 : rp_q + AW'(1);
    assign cnt_d   = cnt_q + CW'(wr) - CW'(rd);
    assign rdata_o = mem_q[rp_q];
    assign cnt_o   = cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk)
        if (wr) mem_q[wp_q] <= wdata_i;
endmodule

// File: rtl/calc_issue.sv
// calc_issue: queues tagged commands, issues one per cycle to the calculator
// under response-FIFO credit, and returns in-order tagged results.
module calc_issue #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int CALC_LAT  = calc_pkg::CALC_LAT
) (
    input logic         clk,
    input logic         reset_n,
    calc_issue_if.slave bus
);
    import calc_pkg::*;
    localparam int CCW = $clog2(CMD_DEPTH + 1);
    localparam int RCW = $clog2(RSP_DEPTH + 1);
    localparam int SW  = $clog2(RSP_DEPTH + CALC_LAT + 1);
    cmd_t           cmd_in, head;
    rsp_t           rsp_in, rsp_head;
    stg_t           stg_d;
    stg_t           pipe_q [CALC_LAT];
    logic [CCW-1:0] cmd_cnt;
    logic [RCW-1:0] rsp_cnt;
    logic [SW-1:0]  infl;
    logic           rdy_q, push, issue, dz, rsp_valid;
    assign cmd_in        = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag};
    assign bus.cmd_ready = rdy_q && cmd_cnt != CCW'(CMD_DEPTH);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    always_comb begin
        infl = '0;
        for (int i = 0; i < CALC_LAT; i++) infl = infl + SW'(pipe_q[i].v);
    end
    // Every in-flight op holds a response slot, so the response FIFO cannot overflow.
    assign issue        = cmd_cnt != '0 && infl + SW'(rsp_cnt) < SW'(RSP_DEPTH);
    assign dz           = head.op == OP_DIV && head.b == 8'd0;
    assign stg_d        = '{v: issue, tag: head.tag, err: dz};
    assign bus.calc_op  = issue && !dz ? head.op : 2'd0;
    assign bus.calc_in1 = issue && !dz ? head.a : 8'd0;
    assign bus.calc_in2 = issue && !dz ? head.b : 8'd0;
    assign rsp_in = '{
        data: pipe_q[CALC_LAT-1].err ? 8'd0 : bus.calc_out,
        tag:  pipe_q[CALC_LAT-1].tag,
        err:  pipe_q[CALC_LAT-1].err
    };
    assign rsp_valid     = rsp_cnt != '0;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_valid ? rsp_head.data : 8'd0;
    assign bus.rsp_tag   = rsp_valid ? rsp_head.tag : '0;
    assign bus.rsp_err   = rsp_valid && rsp_head.err;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q <= 1'b0;
            for (int i = 0; i < CALC_LAT; i++) pipe_q[i] <= '0;
        end else begin
            rdy_q     <= 1'b1;
            pipe_q[0] <= stg_d;
            for (int i = 1; i < CALC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end
    calc_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .reset_n(reset_n), .wr_i(push), .wdata_i(cmd_in),
        .rd_i(issue), .rdata_o(head), .cnt_o(cmd_cnt)
    );
    calc_fifo #(.W($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk(clk), .reset_n(reset_n), .wr_i(pipe_q[CALC_LAT-1].v), .wdata_i(rsp_in),
        .rd_i(rsp_valid && bus.rsp_ready), .rdata_o(rsp_head), .cnt_o(rsp_cnt)
    );
endmodule

// File: doc/calc_issue.md
# calc_issue

Command issuer and response collector for the `calculator` datapath. It takes tagged operation commands through a valid/ready handshake, queues them, and drives `calculator`'s `op`/`in1`/`in2` one command per cycle. It captures `calculator.out` after the fixed pipeline latency and returns in-order tagged responses through a valid/ready handshake. It sits between the host command bus and `calculator`, and is the only master of its inputs.

## Interface
- `CMD_DEPTH`, default 4: command FIFO entries (power of 2, ≥2)
- `RSP_DEPTH`, default 4: response FIFO entries (≥ `CALC_LAT`+2)
- `TAG_W`, default 4: tag width
- `CALC_LAT`, default 2: edges from `calculator` sampling its inputs to `out` holding that result
- `clk` in 1: single clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: command FIFO not full
- `cmd_op` in 2: 00 add, 01 sub, 10 mul, 11 div
- `cmd_a` in 8: operand 1
- `cmd_b` in 8: operand 2
- `cmd_tag` in `TAG_W`: returned with the response
- `calc_op` out 2: to `calculator.op`
- `calc_in1` out 8: to `calculator.in1`
- `calc_in2` out 8: to `calculator.in2`
- `calc_out` in 8: from `calculator.out`
- `rsp_valid` out 1: response FIFO head valid
- `rsp_ready` in 1: consumer accepts
- `rsp_data` out 8: result byte
- `rsp_tag` out `TAG_W`: tag of the command
- `rsp_err` out 1: division by zero

## Operation
- Reset value of every output is 0, including `cmd_ready`. `cmd_ready` rises in the first cycle after `reset_n` deasserts. Both FIFOs and the in-flight pipe are cleared.
- **Command push:** a command is pushed on an edge where `cmd_valid & cmd_ready`. There is no bypass: a pushed command is visible at the FIFO head on the next cycle.
- **Issue condition:** issue = FIFO head valid & (`inflight_cnt` + `rsp_cnt`) < `RSP_DEPTH`, using current-cycle counts with no same-cycle credit return.
  - On issue, `calc_*` are driven combinationally from the head and the head is popped on the edge.
  - On a non-issue cycle, `calc_*` = 0.
- **Division by zero:** `cmd_op`=11 with `cmd_b`=0 is issued with `calc_*` forced to 0 and its err bit set. The response has `rsp_data`=0x00 and `rsp_err`=1, and ordering is preserved.
- **In-flight pipe:** a `CALC_LAT`-deep shift register of {valid, tag, err}.
  - The pipe loads on the issue edge.
  - When the last stage is valid, {`calc_out` (or 0 if err), tag, err} is written to the response FIFO on the next edge.
- **Response FIFO:** show-ahead; pops on `rsp_valid & rsp_ready`. Credit accounting guarantees it never overflows, so a write is never dropped.
- **Result arithmetic:** results follow `calculator` and are mod 256.
  - add and sub wrap.
  - mul returns the low byte.
  - div returns the unsigned floor.
- **Reset mid-operation:** all queued and in-flight commands are discarded and no response is produced for them. `calculator` shares the reset through inversion at the parent.

## Timing
- Empty system, command pushed at edge 0:
  - The issue cycle lies between edges 0 and 1.
  - `calculator` samples at edge 1; its `out` is valid after edge 2.
  - The response is captured at edge 3, so `rsp_valid` is high after edge 3.
  - Accept-to-response latency is `CALC_LAT`+1 = 3 edges.
- **Sustained throughput:** 1 command per cycle while `rsp_ready`=1, with `RSP_DEPTH` ≥ `CALC_LAT`+2.
- **Back-pressure:** with `rsp_ready`=0, issue stops once `inflight_cnt` + `rsp_cnt` reaches `RSP_DEPTH`. `cmd_ready` then drops after `CMD_DEPTH` further pushes.
- **Full command FIFO:** a simultaneous push and pop is not accepted, because `cmd_ready` = !full.
- **Full response FIFO:** a simultaneous write and pop is allowed.

## Structure
- Shared package `calc_pkg`:
  - `op` enum: `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`
  - `CALC_LAT` constant
  - command struct {op, a, b, tag}
  - response struct {data, tag, err}
- One sub-module, `calc_fifo`: a parameterised synchronous show-ahead FIFO, instantiated for both the command and the response queues.
- The issue logic, credit counters and in-flight pipe live in `calc_issue`.

## Test plan
- Single add: push (00, 200, 100, tag 3) -> `rsp_valid` after edge 3 with `rsp_data`=44, `rsp_tag`=3, `rsp_err`=0.
- Back-to-back ops, `rsp_ready`=1: push sub(3,5) tag 1, mul(20,20) tag 2, div(100,7) tag 3 on consecutive edges -> responses 254, 144, 14 in order on consecutive cycles.
- Division by zero: push div(9,0) tag 5 -> `rsp_data`=0, `rsp_err`=1, `rsp_tag`=5; `calc_*` = 0 during its issue cycle.
- Back-pressure: hold `rsp_ready`=0 and push 10 commands -> exactly 4 responses buffered and `cmd_ready`=0 after 8 accepts. Then release `rsp_ready` -> all 8 accepted responses drain in order, followed by the remaining commands once pushed, with no loss or duplication.
- Reset mid-operation: assert `reset_n`=0 with 2 in flight and 3 queued -> all outputs 0 immediately. After release, a new add(1,1) tag 0 returns 2 as the only response.
- Random ordering check: 1000 random commands with random `rsp_ready` -> responses match a reference model (mod-256 result, tags in order).
